// File: rtl/rgmii_rx_frame.sv
// -----------------------------------------------------------------------------
// rgmii_rx_frame
//
// RGMII receive-path framer. Consumes the per-cycle rising/falling-edge samples
// of RXD/RX_CTL (already in the 125 MHz receive clock domain) and produces
// received Ethernet frames as a byte stream with last/error marking. During
// inter-frame gaps it decodes the in-band link status.
//
// Optional feature macro: RGMII_RX_FCS_CHECK_EN
//   defined   -> CRC-32 over all bytes after SFD (including FCS); a residue
//                mismatch at end of frame marks the frame bad.
//   undefined -> no CRC logic; FCS never contributes to m_error.
//   FCS bytes are passed through to m_data in both builds.
//
// Parameters:
//   MAX_LEN      maximum accepted frame length after SFD, including FCS
//   MIN_LEN      minimum frame length; shorter frames are flagged as runts
//
// Ports:
//   clk          RGMII receive clock
//   rst_n        asynchronous active-low reset
//   rxd_rise     RXD sampled on rising edge (low nibble)
//   rxd_fall     RXD sampled on falling edge (high nibble)
//   ctl_rise     RX_CTL rising edge (RX_DV)
//   ctl_fall     RX_CTL falling edge (RX_DV xor RX_ER)
//   m_data       frame byte
//   m_valid      m_data valid this cycle (no backpressure)
//   m_last       final byte of frame, qualified by m_valid
//   m_error      frame bad, valid only with m_last
//   frame_ok     one-cycle pulse with a good m_last
//   frame_err    one-cycle pulse with a bad m_last
//   link_up      in-band link status
//   link_speed   in-band speed: 00=10M, 01=100M, 10=1000M
//   full_duplex  in-band duplex
// -----------------------------------------------------------------------------
module rgmii_rx_frame #(
  parameter int unsigned MAX_LEN = 1518,
  parameter int unsigned MIN_LEN = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] rxd_rise,
  input  logic [3:0] rxd_fall,
  input  logic       ctl_rise,
  input  logic       ctl_fall,
  output logic [7:0] m_data,
  output logic       m_valid,
  output logic       m_last,
  output logic       m_error,
  output logic       frame_ok,
  output logic       frame_err,
  output logic       link_up,
  output logic [1:0] link_speed,
  output logic       full_duplex
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PREAMBLE = 2'd1,
    S_DATA     = 2'd2,
    S_DROP     = 2'd3
  } state_t;

  localparam logic [7:0]  PRE_BYTE  = 8'h55;
  localparam logic [7:0]  SFD_BYTE  = 8'hD5;
  localparam logic [13:0] MAX_LEN_L = 14'(MAX_LEN);
  localparam logic [13:0] MIN_LEN_L = 14'(MIN_LEN);
  localparam logic [13:0] LEN_SAT   = 14'h3FFF;

`ifdef RGMII_RX_FCS_CHECK_EN
  localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;  // 0x04C11DB7 bit-reversed
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;

  // Reflected CRC-32, one byte per call, LSB of the byte first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h00_0000, data};
    for (int i = 0; i < 8; i++) begin
      if (c[0]) begin
        c = (c >> 1) ^ CRC_POLY;
      end else begin
        c = c >> 1;
      end
    end
    return c;
  endfunction
`endif

  // Input stage
  logic [7:0]  byte_q;
  logic        dv_q;
  logic        er_q;

  // Framer state
  state_t      state_q, state_d;
  logic [7:0]  pend_q, pend_d;
  logic [13:0] len_q, len_d;
  logic        err_seen_q, err_seen_d;

  // Output registers
  logic [7:0]  m_data_q, m_data_d;
  logic        m_valid_q, m_valid_d;
  logic        m_last_q, m_last_d;
  logic        m_error_q, m_error_d;
  logic        frame_ok_q, frame_ok_d;
  logic        frame_err_q, frame_err_d;
  logic        link_up_q, link_up_d;
  logic [1:0]  link_speed_q, link_speed_d;
  logic        full_duplex_q, full_duplex_d;

  logic        fcs_bad;
  logic        end_bad;

`ifdef RGMII_RX_FCS_CHECK_EN
  logic [31:0] crc_q, crc_d;
  assign fcs_bad = (crc_q != CRC_RESIDUE);
`else
  assign fcs_bad = 1'b0;
`endif

  // Frame verdict when dv drops; an er on that terminating cycle also counts.
  assign end_bad = err_seen_q | er_q | (len_q < MIN_LEN_L) | fcs_bad;

  // Register the raw DDR samples and decode byte / dv / er.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_q <= 8'h00;
      dv_q   <= 1'b0;
      er_q   <= 1'b0;
    end else begin
      byte_q <= {rxd_fall, rxd_rise};
      dv_q   <= ctl_rise;
      er_q   <= ctl_rise ^ ctl_fall;
    end
  end

  // State, hold register, counters and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      pend_q        <= 8'h00;
      len_q         <= 14'd0;
      err_seen_q    <= 1'b0;
      m_data_q      <= 8'h00;
      m_valid_q     <= 1'b0;
      m_last_q      <= 1'b0;
      m_error_q     <= 1'b0;
      frame_ok_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      link_up_q     <= 1'b0;
      link_speed_q  <= 2'b00;
      full_duplex_q <= 1'b0;
`ifdef RGMII_RX_FCS_CHECK_EN
      crc_q         <= CRC_INIT;
`endif
    end else begin
      state_q       <= state_d;
      pend_q        <= pend_d;
      len_q         <= len_d;
      err_seen_q    <= err_seen_d;
      m_data_q      <= m_data_d;
      m_valid_q     <= m_valid_d;
      m_last_q      <= m_last_d;
      m_error_q     <= m_error_d;
      frame_ok_q    <= frame_ok_d;
      frame_err_q   <= frame_err_d;
      link_up_q     <= link_up_d;
      link_speed_q  <= link_speed_d;
      full_duplex_q <= full_duplex_d;
`ifdef RGMII_RX_FCS_CHECK_EN
      crc_q         <= crc_d;
`endif
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d       = state_q;
    pend_d        = pend_q;
    len_d         = len_q;
    err_seen_d    = err_seen_q;
    m_data_d      = m_data_q;
    m_valid_d     = 1'b0;
    m_last_d      = 1'b0;
    m_error_d     = 1'b0;
    frame_ok_d    = 1'b0;
    frame_err_d   = 1'b0;
    link_up_d     = link_up_q;
    link_speed_d  = link_speed_q;
    full_duplex_d = full_duplex_q;
`ifdef RGMII_RX_FCS_CHECK_EN
    crc_d         = crc_q;
`endif

    case (state_q)
      S_IDLE: begin
        // Per-frame accumulators are cleared while waiting for a frame.
        len_d      = 14'd0;
        err_seen_d = 1'b0;
`ifdef RGMII_RX_FCS_CHECK_EN
        crc_d      = CRC_INIT;
`endif
        if (!dv_q) begin
          if (!er_q) begin
            // Plain inter-frame gap carries in-band status on the low nibble.
            link_up_d     = byte_q[0];
            link_speed_d  = byte_q[2:1];
            full_duplex_d = byte_q[3];
          end else begin
            link_up_d     = link_up_q;
          end
          state_d = S_IDLE;
        end else if (byte_q == PRE_BYTE) begin
          state_d = S_PREAMBLE;
        end else if (byte_q == SFD_BYTE) begin
          state_d = S_DATA;
        end else begin
          state_d = S_DROP;
        end
      end

      S_PREAMBLE: begin
        len_d      = 14'd0;
        err_seen_d = 1'b0;
`ifdef RGMII_RX_FCS_CHECK_EN
        crc_d      = CRC_INIT;
`endif
        if (!dv_q) begin
          state_d = S_IDLE;
        end else if (er_q) begin
          state_d = S_DROP;
        end else if (byte_q == PRE_BYTE) begin
          state_d = S_PREAMBLE;
        end else if (byte_q == SFD_BYTE) begin
          state_d = S_DATA;
        end else begin
          state_d = S_DROP;
        end
      end

      S_DATA: begin
        if (!dv_q) begin
          // End of carrier: flush the held byte as the last one, if any.
          state_d = S_IDLE;
          if (len_q != 14'd0) begin
            m_valid_d   = 1'b1;
            m_data_d    = pend_q;
            m_last_d    = 1'b1;
            m_error_d   = end_bad;
            frame_ok_d  = ~end_bad;
            frame_err_d = end_bad;
          end else begin
            m_valid_d   = 1'b0;
          end
        end else if (len_q == MAX_LEN_L) begin
          // One byte beyond the maximum: close the frame as oversize.
          state_d     = S_DROP;
          m_valid_d   = 1'b1;
          m_data_d    = pend_q;
          m_last_d    = 1'b1;
          m_error_d   = 1'b1;
          frame_err_d = 1'b1;
        end else begin
          // Hold each byte one cycle so the final byte can carry m_last.
          pend_d     = byte_q;
          err_seen_d = err_seen_q | er_q;
`ifdef RGMII_RX_FCS_CHECK_EN
          crc_d      = crc32_byte(crc_q, byte_q);
`endif
          if (len_q != LEN_SAT) begin
            len_d = len_q + 14'd1;
          end else begin
            len_d = len_q;
          end
          if (len_q != 14'd0) begin
            m_valid_d = 1'b1;
            m_data_d  = pend_q;
          end else begin
            m_valid_d = 1'b0;
          end
        end
      end

      S_DROP: begin
        if (!dv_q) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DROP;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign m_data      = m_data_q;
  assign m_valid     = m_valid_q;
  assign m_last      = m_last_q;
  assign m_error     = m_error_q;
  assign frame_ok    = frame_ok_q;
  assign frame_err   = frame_err_q;
  assign link_up     = link_up_q;
  assign link_speed  = link_speed_q;
  assign full_duplex = full_duplex_q;

endmodule

// File: tb/tb_rgmii_rx_frame.sv
// Scoreboard bench for rgmii_rx_frame: the stimulus thread builds each frame,
// derives its expected beats from the frame-level rules (length limits, error
// bytes, appended FCS vs. recomputed CRC) and queues them; an independent
// monitor pops and compares whenever the DUT presents a beat.
module tb_rgmii_rx_frame;

  localparam int MAX_LEN = 1518;
  localparam int MIN_LEN = 64;

  logic       clk;
  logic       rst_n;
  logic [3:0] rxd_rise;
  logic [3:0] rxd_fall;
  logic       ctl_rise;
  logic       ctl_fall;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_last;
  logic       m_error;
  logic       frame_ok;
  logic       frame_err;
  logic       link_up;
  logic [1:0] link_speed;
  logic       full_duplex;

  typedef struct packed {
    logic [7:0]  data;
    logic        last;
    logic        err;
    logic [31:0] cyc;
  } beat_t;

  beat_t       expq[$];
  beat_t       mon_e;
  logic [7:0]  fr[$];
  int          n_checks   = 0;
  int          n_pass     = 0;
  int          exp_ok     = 0;
  int          seen_ok    = 0;
  logic [31:0] cycle_cnt  = 32'd0;
  logic        mon_ignore = 1'b1;
  logic [3:0]  status_nib = 4'h0;

  rgmii_rx_frame #(.MAX_LEN(MAX_LEN), .MIN_LEN(MIN_LEN)) dut (
    .clk(clk), .rst_n(rst_n),
    .rxd_rise(rxd_rise), .rxd_fall(rxd_fall),
    .ctl_rise(ctl_rise), .ctl_fall(ctl_fall),
    .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_error(m_error),
    .frame_ok(frame_ok), .frame_err(frame_err),
    .link_up(link_up), .link_speed(link_speed), .full_duplex(full_duplex)
  );

  initial clk = 1'b0;
  always #4 clk = ~clk;

  always @(posedge clk) cycle_cnt <= cycle_cnt + 32'd1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  // Status nibble {fd, speed, up} mapped to {link_up, link_speed, full_duplex}.
  function automatic logic [3:0] status_exp(input logic [3:0] nib);
    return {nib[0], nib[2:1], nib[3]};
  endfunction

  // Ethernet FCS of the first len bytes of fr (value to transmit, LSB first).
  function automatic logic [31:0] fcs_of(input int len);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < len; i++) begin
      c = c ^ {24'd0, fr[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic drive(input logic [7:0] b, input logic dv, input logic er);
    @(posedge clk); #1;
    rxd_rise = b[3:0];
    rxd_fall = b[7:4];
    ctl_rise = dv;
    ctl_fall = dv ^ er;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive({4'h0, status_nib}, 1'b0, 1'b0);
  endtask

  // npre x 0x55 + SFD (or 0x55,0x57 when bad_pre), n bytes, er on byte er_idx.
  task automatic send_frame(input int npre, input logic bad_pre, input int n,
                            input int er_idx, input logic flip, input int gap);
    logic [31:0] fcs;
    logic        bad;
    int          nb;
    fr.delete();
    if (n >= 4) begin
      for (int i = 0; i < n - 4; i++) fr.push_back(8'($urandom));
      fcs = fcs_of(n - 4);
      for (int k = 0; k < 4; k++) fr.push_back(fcs[8*k +: 8]);
      if (flip) fr[n-1] = fr[n-1] ^ 8'h10;
    end else begin
      for (int i = 0; i < n; i++) fr.push_back(8'($urandom));
    end
    nb  = (n > MAX_LEN) ? MAX_LEN : n;
    bad = (n < MIN_LEN) || (n > MAX_LEN) || (er_idx >= 0 && er_idx < n);
`ifdef RGMII_RX_FCS_CHECK_EN
    if (n >= 4) bad = bad || ({fr[n-1], fr[n-2], fr[n-3], fr[n-4]} != fcs_of(n - 4));
`endif
    if (bad_pre) begin
      drive(8'h55, 1'b1, 1'b0);
      drive(8'h57, 1'b1, 1'b0);
    end else begin
      for (int i = 0; i < npre; i++) drive(8'h55, 1'b1, 1'b0);
      drive(8'hD5, 1'b1, 1'b0);
    end
    for (int i = 0; i < n; i++) begin
      drive(fr[i], 1'b1, (i == er_idx));
      if (!bad_pre && i < nb)
        expq.push_back('{data: fr[i], last: (i == nb - 1), err: (i == nb - 1) && bad,
                         cyc: cycle_cnt + 32'd3});
    end
    if (!bad_pre && nb > 0 && !bad) exp_ok++;
    idle(gap);
  endtask

  // Monitor: compare each presented beat with the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && !mon_ignore) begin
      if (m_valid) begin
        if (expq.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_beat: actual data=%0h last=%0b at cycle %0d, required no beat",
                   m_data, m_last, cycle_cnt);
        end else begin
          mon_e = expq.pop_front();
          check("beat{data,last,err,cycle}", {22'd0, m_data, m_last, m_error, cycle_cnt},
                {22'd0, mon_e.data, mon_e.last, mon_e.err, mon_e.cyc});
          check("beat_pulses{ok,err}", {62'd0, frame_ok, frame_err},
                {62'd0, mon_e.last & ~mon_e.err, mon_e.last & mon_e.err});
          if (frame_ok) seen_ok++;
        end
      end else begin
        check("idle_pulses{ok,err}", {62'd0, frame_ok, frame_err}, 64'd0);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] nib;
    rst_n = 1'b0; rxd_rise = 4'h0; rxd_fall = 4'h0; ctl_rise = 1'b0; ctl_fall = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("reset_outputs", {47'd0, m_data, m_valid, m_last, m_error, frame_ok, frame_err,
                            link_up, link_speed, full_duplex}, 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    idle(3);
    check("post_reset_status", {60'd0, link_up, link_speed, full_duplex}, 64'd0);
    mon_ignore = 1'b0;

    // Status latency: new status visible exactly 2 cycles after its sample.
    status_nib = 4'hD;
    drive({4'h0, status_nib}, 1'b0, 1'b0);
    @(negedge clk); check("status_t0", {60'd0, link_up, link_speed, full_duplex}, 64'h0);
    drive({4'h0, status_nib}, 1'b0, 1'b0);
    @(negedge clk); check("status_t1", {60'd0, link_up, link_speed, full_duplex}, 64'h0);
    drive({4'h0, status_nib}, 1'b0, 1'b0);
    @(negedge clk); check("status_t2", {60'd0, link_up, link_speed, full_duplex}, 64'b1101);
    // er during the gap must not update status.
    repeat (3) drive(8'h02, 1'b0, 1'b1);
    @(negedge clk); check("status_er_hold", {60'd0, link_up, link_speed, full_duplex}, 64'b1101);
    for (int i = 0; i < 3; i++) begin
      nib = {1'($urandom), 2'($urandom_range(0, 2)), 1'($urandom)};
      status_nib = nib;
      idle(4);
      @(negedge clk);
      check("status_random", {60'd0, link_up, link_speed, full_duplex}, {60'd0, status_exp(nib)});
    end

    send_frame(7, 1'b0, 64,   -1, 1'b0, 12);  // good 64-byte frame
    send_frame(7, 1'b0, 64,   19, 1'b0, 12);  // er on byte 20
    send_frame(7, 1'b0, 40,   -1, 1'b0, 12);  // runt
    send_frame(5, 1'b0, 63,   -1, 1'b0, 8);   // one below minimum
    send_frame(5, 1'b0, 1600, -1, 1'b0, 12);  // oversize
    send_frame(7, 1'b0, 64,   -1, 1'b0, 8);
    send_frame(7, 1'b0, 1518, -1, 1'b0, 8);   // exactly maximum
    send_frame(7, 1'b0, 1519, -1, 1'b0, 8);   // one above maximum
    send_frame(0, 1'b1, 30,   -1, 1'b0, 6);   // broken preamble
    send_frame(0, 1'b0, 64,   -1, 1'b0, 6);   // SFD with no preamble
    send_frame(3, 1'b0, 70,   -1, 1'b0, 1);   // back-to-back, 1-cycle gaps
    send_frame(3, 1'b0, 80,   -1, 1'b0, 1);
    send_frame(2, 1'b0, 64,   -1, 1'b0, 8);
    send_frame(7, 1'b0, 64,   -1, 1'b1, 8);   // flipped FCS bit
    send_frame(2, 1'b0, 0,    -1, 1'b0, 5);   // SFD then dv drop
    for (int f = 0; f < 25; f++) begin
      send_frame($urandom_range(0, 7), ($urandom_range(0, 7) == 0), $urandom_range(20, 150),
                 ($urandom_range(0, 4) == 0) ? $urandom_range(0, 19) : -1,
                 ($urandom_range(0, 4) == 0), $urandom_range(1, 4));
    end

    // Reset in the middle of a frame: outputs clear at once, no m_last later.
    idle(4);
    mon_ignore = 1'b1;
    for (int i = 0; i < 4; i++) drive(8'h55, 1'b1, 1'b0);
    drive(8'hD5, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) drive(8'($urandom), 1'b1, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    check("reset_midframe", {47'd0, m_data, m_valid, m_last, m_error, frame_ok, frame_err,
                             link_up, link_speed, full_duplex}, 64'd0);
    idle(2);
    rst_n = 1'b1;
    mon_ignore = 1'b0;
    idle(5);
    @(negedge clk);
    check("status_relatch", {60'd0, link_up, link_speed, full_duplex}, {60'd0, status_exp(status_nib)});
    send_frame(7, 1'b0, 64, -1, 1'b0, 12);

    idle(10);
    check("scoreboard_drained", 64'(expq.size()), 64'd0);
    check("frame_ok_count", 64'(seen_ok), 64'(exp_ok));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rgmii_rx_frame.md
# rgmii_rx_frame

RGMII receive-path framer. Takes the per-cycle rising/falling-edge samples of RXD/RX_CTL from the DDR input registers, already in the 125 MHz receive clock domain. Outputs received Ethernet frames as a byte stream with last/error marking. Also decodes in-band link status during inter-frame gaps. Sits between the RGMII I/O capture cells and the MAC receive logic. It is the receive counterpart of the TX clocking/transmit path.

## Interface
- `MAX_LEN`, 1518: maximum accepted frame length in bytes, counted after SFD and including FCS; range 64..16383.
- `MIN_LEN`, 64: minimum frame length in bytes, including FCS; shorter frames are flagged as runts.
- `clk`  in  1  RGMII receive clock (125 MHz).
- `rst_n`  in  1  asynchronous active-low reset.
- `rxd_rise`  in  4  RXD sampled on the rising edge (low nibble).
- `rxd_fall`  in  4  RXD sampled on the falling edge (high nibble).
- `ctl_rise`  in  1  RX_CTL on the rising edge (RX_DV).
- `ctl_fall`  in  1  RX_CTL on the falling edge (RX_DV xor RX_ER).
- `m_data`  out  8  frame byte.
- `m_valid`  out  1  `m_data` valid this cycle. No backpressure.
- `m_last`  out  1  final byte of the frame; qualified by `m_valid`.
- `m_error`  out  1  frame bad; valid only with `m_last`.
- `frame_ok`  out  1  one-cycle pulse, coincident with a good `m_last`.
- `frame_err`  out  1  one-cycle pulse, coincident with a bad `m_last`.
- `link_up`  out  1  in-band link status.
- `link_speed`  out  2  in-band speed: 00 = 10M, 01 = 100M, 10 = 1000M.
- `full_duplex`  out  1  in-band duplex.

## Operation
- Input decode:
  - Input stage registers all input ports, one cycle.
  - `byte = {rxd_fall, rxd_rise}`, `dv = ctl_rise`, `er = ctl_rise ^ ctl_fall`.
- FSM states: IDLE, PREAMBLE, DATA, DROP.
- IDLE:
  - `dv=0, er=0` → latch `link_up = rxd_rise[0]`, `link_speed = rxd_rise[2:1]`, `full_duplex = rxd_rise[3]`.
  - `dv=1`: byte 0x55 → PREAMBLE; byte 0xD5 → DATA; any other byte → DROP.
- PREAMBLE:
  - 0x55 → stay; 0xD5 → DATA; any other byte, or `er` → DROP.
  - `dv=0` → IDLE; nothing is emitted.
- DATA:
  - Each byte goes into a one-byte hold register (`pend`). The previous `pend` is emitted with `m_last=0`.
  - On `dv=0`: emit `pend` with `m_last=1`, then go to IDLE.
  - Byte counter `len` (14 bit, saturating) counts bytes after SFD. Any `er` while in DATA sets a sticky `err_seen`.
  - When a byte arrives with `len == MAX_LEN`: emit `pend` with `m_last=1, m_error=1` → DROP.
- DROP: ignore all input until `dv=0`, then go to IDLE; no output.
- `m_error` on `m_last` = `err_seen` | (`len < MIN_LEN`) | oversize | FCS fail (when the check is compiled in).
- SFD immediately followed by `dv=0`: zero bytes, nothing emitted, no pulse.
- Output registers reset values: `m_data=0`, `m_valid=0`, `m_last=0`, `m_error=0`, `frame_ok=0`, `frame_err=0`, `link_up=0`, `link_speed=00`, `full_duplex=0`. FSM resets to IDLE, `len=0`, `err_seen=0`.

## Timing
- Latency: a byte presented in cycle t appears on `m_data` in cycle t+3.
- Final byte: the first `dv=0` cycle after the last byte is cycle t+1; the final byte appears in cycle t+3 with `m_last=1`.
- `frame_ok`/`frame_err` assert in the same cycle as `m_last`.
- Back-to-back frames: the minimum 1-cycle gap (`dv=0`) between frames is supported with no loss.
- Status update: status outputs change 2 cycles after the IDLE input sample that carries them.
- Reset mid-frame: outputs clear immediately; no `m_last` is generated for the aborted frame.

## Configuration
- `RGMII_RX_FCS_CHECK_EN` defined:
  - CRC-32 (poly 0x04C11DB7, reflected, init 0xFFFFFFFF) runs byte-wise over every byte after SFD, including FCS.
  - At `m_last`, a register value ≠ residue 0xDEBB20E3 (non-inverted form) sets `m_error`.
- Undefined: no CRC logic is built, and FCS is never a cause of `m_error`.
- FCS bytes are passed to `m_data` in both builds.

## Test plan
- 7×0x55, 0xD5, then a 64-byte frame with a valid FCS → 64 `m_valid` beats with data matching the input, `m_last` on beat 64, `m_error=0`, one `frame_ok` pulse, first beat 3 cycles after the first data byte.
- Same frame with `er` asserted on byte 20 → 64 beats, `m_error=1` on last, one `frame_err` pulse.
- 40-byte frame → 40 beats, `m_error=1` (runt).
- 1600-byte frame with `MAX_LEN=1518` → exactly 1518 beats, last beat has `m_last=1, m_error=1`, no further output until `dv` drops and a new frame starts.
- Preamble 0x55, 0x57 then data → no `m_valid` for the whole burst; next valid frame is received correctly. Two frames separated by a 1-cycle gap → both delivered intact.
- IDLE with `rxd_rise=0xD`, `dv=0, er=0` → `link_up=1`, `link_speed=10`, `full_duplex=1` after 2 cycles. With `RGMII_RX_FCS_CHECK_EN` defined, flipping one FCS bit gives `m_error=1`; without it, the same frame gives `m_error=0`.
